// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mips_defs
// Brief    : Shared MIPS encodings: opcodes, functs, ALU codes, mux selects
//            and small decode helpers used by the multicycle sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mips_defs;

    // Primary opcodes (IR[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_SLTI  = 6'h0A;
    localparam logic [5:0] c_OP_ANDI  = 6'h0C;
    localparam logic [5:0] c_OP_ORI   = 6'h0D;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] c_FN_ADD = 6'h20;
    localparam logic [5:0] c_FN_SUB = 6'h22;
    localparam logic [5:0] c_FN_AND = 6'h24;
    localparam logic [5:0] c_FN_OR  = 6'h25;
    localparam logic [5:0] c_FN_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    // ALU B operand select
    localparam logic [1:0] c_SRCB_REG   = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_BRIMM = 2'b11;

    // PC source select
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    // Returns {valid, alu_ctrl} for an R-type funct field
    function automatic logic [3:0] funct_to_alu(input logic [5:0] funct);
        case (funct)
            c_FN_ADD: return {1'b1, c_ALU_ADD};
            c_FN_SUB: return {1'b1, c_ALU_SUB};
            c_FN_AND: return {1'b1, c_ALU_AND};
            c_FN_OR:  return {1'b1, c_ALU_OR};
            c_FN_SLT: return {1'b1, c_ALU_SLT};
            default:  return {1'b0, c_ALU_ADD};
        endcase
    endfunction

    // Returns {sign_ext, alu_ctrl} for an immediate-form opcode
    function automatic logic [3:0] imm_to_alu(input logic [5:0] op);
        case (op)
            c_OP_ADDI: return {1'b1, c_ALU_ADD};
            c_OP_SLTI: return {1'b1, c_ALU_SLT};
            c_OP_ORI:  return {1'b0, c_ALU_OR};
            c_OP_ANDI: return {1'b0, c_ALU_AND};
            default:   return {1'b1, c_ALU_ADD};
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/multicycle_ctrl_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : mc_wait_timer
// Brief    : 8-bit memory wait counter. o_limit_hit flags that the current
//            cycle is the WAIT_LIMIT-th consecutive waiting cycle.
// Revision : 1.0 - initial release
// ============================================================================
module mc_wait_timer #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_limit_hit
);

    // Counter holds the number of waiting cycles already completed, so the
    // cycle being evaluated is number r_count + 1.
    localparam logic [7:0] c_LAST_IDX = 8'(WAIT_LIMIT - 1);

    logic [7:0] r_count;

    // Clear has priority; increment saturates so the counter never wraps
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_limit_hit = (r_count == c_LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_ctrl
// Brief    : Moore sequencer for the multicycle MIPS datapath with a shared
//            memory port, mem_ready handshake and bounded wait.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       ir_wr,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_wr,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic       sign_ext,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout
);
    import mips_defs::*;

    typedef enum logic [3:0] {
        c_ST_FETCH   = 4'd0,
        c_ST_DECODE  = 4'd1,
        c_ST_MEM_ADR = 4'd2,
        c_ST_MEM_RD  = 4'd3,
        c_ST_MEM_WB  = 4'd4,
        c_ST_MEM_WR  = 4'd5,
        c_ST_EXEC_R  = 4'd6,
        c_ST_R_WB    = 4'd7,
        c_ST_EXEC_I  = 4'd8,
        c_ST_I_WB    = 4'd9,
        c_ST_BRANCH  = 4'd10,
        c_ST_JUMP    = 4'd11
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       r_is_bne;
    logic [3:0] w_fn;
    logic [3:0] w_imm;
    logic       w_in_wait;
    logic       w_waiting;
    logic       w_limit_hit;
    logic       w_timeout;
    logic       w_clear;

    assign w_fn      = funct_to_alu(funct);
    assign w_imm     = imm_to_alu(op);
    assign w_in_wait = (r_state == c_ST_FETCH) || (r_state == c_ST_MEM_RD) ||
                       (r_state == c_ST_MEM_WR);
    assign w_waiting = w_in_wait && !mem_ready;
    assign w_timeout = w_waiting && w_limit_hit;
    // Any state change re-arms the counter; a FETCH timeout re-enters FETCH
    // without a state change, so it clears explicitly.
    assign w_clear   = (w_next != r_state) || w_timeout;

    mc_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_clear),
        .i_enable    (w_waiting),
        .o_limit_hit (w_limit_hit)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Branch sense captured while the opcode is decoded
    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_bne <= 1'b0;
        end else if (r_state == c_ST_DECODE) begin
            r_is_bne <= (op == c_OP_BNE);
        end
    end

    // Next-state and control-word decode
    always_comb begin
        w_next      = r_state;
        pc_en       = 1'b0;
        iord        = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        ir_wr       = 1'b0;
        mem_to_reg  = 1'b0;
        reg_dst     = 1'b0;
        reg_wr      = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = c_SRCB_REG;
        alu_ctrl    = 3'b000;
        pc_src      = c_PCSRC_ALU;
        sign_ext    = 1'b1;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        case (r_state)
            c_ST_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = c_SRCB_FOUR;
                alu_ctrl  = c_ALU_ADD;
                if (mem_ready) begin
                    ir_wr  = 1'b1;
                    pc_en  = 1'b1;
                    w_next = c_ST_DECODE;
                end else if (w_limit_hit) begin
                    mem_timeout = 1'b1;
                    w_next      = c_ST_FETCH;
                end
            end
            c_ST_DECODE: begin
                alu_src_b = c_SRCB_BRIMM;
                alu_ctrl  = c_ALU_ADD;
                case (op)
                    c_OP_LW, c_OP_SW: w_next = c_ST_MEM_ADR;
                    c_OP_RTYPE: begin
                        if (w_fn[3]) begin
                            w_next = c_ST_EXEC_R;
                        end else begin
                            illegal_op = 1'b1;
                            w_next     = c_ST_FETCH;
                        end
                    end
                    c_OP_ADDI, c_OP_SLTI, c_OP_ORI, c_OP_ANDI: w_next = c_ST_EXEC_I;
                    c_OP_BEQ, c_OP_BNE: w_next = c_ST_BRANCH;
                    c_OP_J: w_next = c_ST_JUMP;
                    default: begin
                        illegal_op = 1'b1;
                        w_next     = c_ST_FETCH;
                    end
                endcase
            end
            c_ST_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_IMM;
                alu_ctrl  = c_ALU_ADD;
                w_next    = (op == c_OP_LW) ? c_ST_MEM_RD : c_ST_MEM_WR;
            end
            c_ST_MEM_RD: begin
                iord   = 1'b1;
                mem_rd = 1'b1;
                if (mem_ready) begin
                    w_next = c_ST_MEM_WB;
                end else if (w_limit_hit) begin
                    mem_timeout = 1'b1;
                    w_next      = c_ST_FETCH;
                end
            end
            c_ST_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_wr     = 1'b1;
                instr_done = 1'b1;
                w_next     = c_ST_FETCH;
            end
            c_ST_MEM_WR: begin
                iord   = 1'b1;
                mem_wr = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    w_next     = c_ST_FETCH;
                end else if (w_limit_hit) begin
                    mem_timeout = 1'b1;
                    w_next      = c_ST_FETCH;
                end
            end
            c_ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_REG;
                alu_ctrl  = w_fn[2:0];
                w_next    = c_ST_R_WB;
            end
            c_ST_R_WB: begin
                reg_dst    = 1'b1;
                reg_wr     = 1'b1;
                instr_done = 1'b1;
                w_next     = c_ST_FETCH;
            end
            c_ST_EXEC_I, c_ST_I_WB: begin
                // Write-back keeps the immediate path stable while it retires
                alu_src_a = 1'b1;
                alu_src_b = c_SRCB_IMM;
                alu_ctrl  = w_imm[2:0];
                sign_ext  = w_imm[3];
                if (r_state == c_ST_EXEC_I) begin
                    w_next = c_ST_I_WB;
                end else begin
                    reg_wr     = 1'b1;
                    instr_done = 1'b1;
                    w_next     = c_ST_FETCH;
                end
            end
            c_ST_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_src_b  = c_SRCB_REG;
                alu_ctrl   = c_ALU_SUB;
                pc_src     = c_PCSRC_ALUOUT;
                pc_en      = zero ^ r_is_bne;
                instr_done = 1'b1;
                w_next     = c_ST_FETCH;
            end
            c_ST_JUMP: begin
                pc_src     = c_PCSRC_JUMP;
                pc_en      = 1'b1;
                instr_done = 1'b1;
                w_next     = c_ST_FETCH;
            end
            default: w_next = c_ST_FETCH;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_ctrl
// Brief    : Scoreboard bench for multicycle_ctrl. Each instruction is planned
//            as a cycle timeline of expected control words and a retirement
//            record; a monitor compares what the controller presents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

    localparam int LIM = 4;

    localparam logic [2:0] K_DONE = 3'b001;
    localparam logic [2:0] K_ILL  = 3'b010;
    localparam logic [2:0] K_TO   = 3'b100;

    localparam int C_MEM = 0, C_R = 1, C_I = 2, C_BR = 3, C_J = 4, C_ILL = 5;

    typedef struct packed {
        logic       pc_en, iord, mem_rd, mem_wr, ir_wr, mem_to_reg, reg_dst, reg_wr, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic       sign_ext, instr_done, illegal_op, mem_timeout;
    } cw_t;

    typedef struct packed {
        logic rst;
        logic rdy;
        cw_t  cw;
    } step_t;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] lat;
    } comp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, mem_rd, mem_wr, ir_wr, mem_to_reg, reg_dst, reg_wr, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic       sign_ext, instr_done, illegal_op, mem_timeout;

    step_t plan[$];
    cw_t   exp_q[$];
    comp_t comp_q[$];
    int    n_chk = 0;
    int    n_pass = 0;
    int    cyc = 0;

    multicycle_ctrl #(.WAIT_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .pc_en(pc_en), .iord(iord), .mem_rd(mem_rd), .mem_wr(mem_wr), .ir_wr(ir_wr),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_wr(reg_wr), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src), .sign_ext(sign_ext),
        .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    // ---------------- reference model: instruction -> cycle timeline ----------------
    function automatic cw_t base_cw();
        cw_t c = '0;
        c.sign_ext = 1'b1;
        return c;
    endfunction

    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h23, 6'h2B: return C_MEM;
            6'h00: return (f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h2A) ? C_R : C_ILL;
            6'h08, 6'h0A, 6'h0C, 6'h0D: return C_I;
            6'h04, 6'h05: return C_BR;
            6'h02: return C_J;
            default: return C_ILL;
        endcase
    endfunction

    function automatic logic [2:0] r_alu(input logic [5:0] f);
        case (f)
            6'h20: return 3'b010;
            6'h22: return 3'b110;
            6'h24: return 3'b000;
            6'h25: return 3'b001;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [2:0] i_alu(input logic [5:0] o);
        case (o)
            6'h08: return 3'b010;
            6'h0A: return 3'b111;
            6'h0C: return 3'b000;
            default: return 3'b001;
        endcase
    endfunction

    task automatic add_step(input cw_t c, input logic rdy);
        step_t s;
        s.rst = 1'b0;
        s.rdy = rdy;
        s.cw  = c;
        plan.push_back(s);
    endtask

    // Non-memory cycle: mem_ready is irrelevant, so drive it randomly
    task automatic add_free(input cw_t c);
        add_step(c, 1'($urandom_range(0, 1)));
    endtask

    // Memory access with n low cycles before ready; abandoned on the LIM-th low cycle
    task automatic add_wait(input cw_t base, input cw_t fin, input int n, output bit ok);
        cw_t c;
        ok = 1'b1;
        for (int i = 0; i < n && i < LIM; i++) begin
            c = base;
            if (i == LIM - 1) begin
                c.mem_timeout = 1'b1;
                add_step(c, 1'b0);
                ok = 1'b0;
                return;
            end
            add_step(c, 1'b0);
        end
        add_step(fin, 1'b1);
    endtask

    task automatic plan_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                              input int wf, input int wm, output logic [2:0] kind);
        cw_t c, fin;
        bit  ok;
        int  cl;
        plan.delete();
        kind = K_DONE;
        c = base_cw(); c.mem_rd = 1; c.alu_src_b = 2'b01; c.alu_ctrl = 3'b010;
        fin = c; fin.ir_wr = 1; fin.pc_en = 1;
        add_wait(c, fin, wf, ok);
        if (!ok) begin kind = K_TO; return; end
        cl = classify(o, f);
        c = base_cw(); c.alu_src_b = 2'b11; c.alu_ctrl = 3'b010;
        if (cl == C_ILL) begin
            c.illegal_op = 1;
            add_free(c);
            kind = K_ILL;
            return;
        end
        add_free(c);
        case (cl)
            C_MEM: begin
                c = base_cw(); c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctrl = 3'b010;
                add_free(c);
                c = base_cw(); c.iord = 1;
                if (o == 6'h23) begin
                    c.mem_rd = 1;
                    add_wait(c, c, wm, ok);
                    if (!ok) begin kind = K_TO; return; end
                    c = base_cw(); c.mem_to_reg = 1; c.reg_wr = 1; c.instr_done = 1;
                    add_free(c);
                end else begin
                    c.mem_wr = 1;
                    fin = c; fin.instr_done = 1;
                    add_wait(c, fin, wm, ok);
                    if (!ok) kind = K_TO;
                end
            end
            C_R: begin
                c = base_cw(); c.alu_src_a = 1; c.alu_ctrl = r_alu(f);
                add_free(c);
                c = base_cw(); c.reg_dst = 1; c.reg_wr = 1; c.instr_done = 1;
                add_free(c);
            end
            C_I: begin
                c = base_cw(); c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_ctrl = i_alu(o);
                c.sign_ext = (o == 6'h08 || o == 6'h0A);
                add_free(c);
                c.reg_wr = 1; c.instr_done = 1;
                add_free(c);
            end
            C_BR: begin
                c = base_cw(); c.alu_src_a = 1; c.alu_ctrl = 3'b110; c.pc_src = 2'b01;
                c.instr_done = 1; c.pc_en = z ^ (o == 6'h05);
                add_free(c);
            end
            default: begin
                c = base_cw(); c.pc_src = 2'b10; c.pc_en = 1; c.instr_done = 1;
                add_free(c);
            end
        endcase
    endtask

    // ---------------- driver ----------------
    task automatic run_plan(input logic [5:0] o, input logic [5:0] f, input logic z);
        for (int i = 0; i < plan.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin op = o; funct = f; zero = z; end
            rst       = plan[i].rst;
            mem_ready = plan[i].rdy;
            exp_q.push_back(plan[i].cw);
        end
    endtask

    task automatic do_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int wf, input int wm);
        logic [2:0] k;
        comp_t      e;
        plan_instr(o, f, z, wf, wm, k);
        e.kind = k;
        e.lat  = 16'(plan.size());
        comp_q.push_back(e);
        run_plan(o, f, z);
    endtask

    // ---------------- monitor ----------------
    cw_t        m_act, m_exp;
    comp_t      m_comp;
    logic [2:0] m_pulse;

    always @(negedge clk) begin
        m_act = '{pc_en, iord, mem_rd, mem_wr, ir_wr, mem_to_reg, reg_dst, reg_wr, alu_src_a,
                  alu_src_b, alu_ctrl, pc_src, sign_ext, instr_done, illegal_op, mem_timeout};
        if (exp_q.size() > 0) begin
            m_exp = exp_q.pop_front();
            check("ctrl_word", 32'(m_act), 32'(m_exp));
        end
        m_pulse = {mem_timeout, illegal_op, instr_done};
        if (rst === 1'b1) begin
            cyc = 0;
        end else begin
            cyc++;
            if (m_pulse !== 3'b000) begin
                if (comp_q.size() == 0) begin
                    check("spurious_end", 32'(m_pulse), 32'd0);
                end else begin
                    m_comp = comp_q.pop_front();
                    check("end_kind", 32'(m_pulse), 32'(m_comp.kind));
                    check("latency", 32'(cyc), 32'(m_comp.lat));
                end
                cyc = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    logic [5:0] ops[10] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B};
    logic [5:0] fns[5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    initial begin
        logic [5:0] o, f;
        logic [2:0] k;
        step_t      s;
        int         wf, wm;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        // Directed: reset FETCH values (first cycle mem_ready low), then the plan items
        do_instr(6'h00, 6'h20, 1'b0, 1, 0);      // add
        do_instr(6'h23, 6'h00, 1'b0, 0, 2);      // lw, 2 data wait cycles
        do_instr(6'h04, 6'h00, 1'b1, 0, 0);      // beq taken
        do_instr(6'h05, 6'h00, 1'b1, 0, 0);      // bne not taken
        do_instr(6'h0D, 6'h00, 1'b0, 0, 0);      // ori
        do_instr(6'h0A, 6'h00, 1'b0, 0, 0);      // slti
        do_instr(6'h3F, 6'h00, 1'b0, 0, 0);      // illegal op
        do_instr(6'h00, 6'h27, 1'b0, 0, 0);      // illegal funct
        do_instr(6'h2B, 6'h00, 1'b0, 0, LIM);    // sw timeout
        do_instr(6'h02, 6'h00, 1'b0, LIM + 2, 0); // fetch timeout
        do_instr(6'h2B, 6'h00, 1'b0, 0, LIM - 1); // sw ready on the limit cycle
        // Reset while MEM_RD waits: interrupted lw never writes back
        plan_instr(6'h23, 6'h00, 1'b0, 0, 3, k);
        while (plan.size() > 4) void'(plan.pop_back());
        s = plan[3];
        s.rst = 1'b1;
        plan[3] = s;
        run_plan(6'h23, 6'h00, 1'b0);
        do_instr(6'h00, 6'h2A, 1'b0, 0, 0);      // slt
        // Randomized traffic
        repeat (150) begin
            if ($urandom_range(0, 15) < 13) o = ops[$urandom_range(0, 9)];
            else o = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) f = 6'($urandom_range(0, 63));
            else f = fns[$urandom_range(0, 4)];
            wf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LIM + 1)) : int'($urandom_range(0, 2));
            wm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, LIM + 1)) : int'($urandom_range(0, 2));
            do_instr(o, f, 1'($urandom_range(0, 1)), wf, wm);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        check("leftover_retire", 32'(comp_q.size()), 32'd0);
        check("leftover_cycles", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencer for the MIPS datapath: a Moore FSM that drives a shared instruction/data memory port, the instruction register, the register file, the ALU and the PC over several cycles per instruction. It replaces single-cycle decode when the datapath is rebuilt around one memory and one ALU. It supports the same instruction subset: R-type add/sub/and/or/slt, lw, sw, beq, bne, addi, slti, ori, andi and j. It adds a memory ready handshake with a bounded wait.

## Interface
- WAIT_LIMIT, default 255: maximum consecutive cycles spent waiting for mem_ready before the access is abandoned. Allowed range is 1..255.

All ports below are on one clock. Reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- op  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_en  out  1  PC load enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_rd, mem_wr  out  1 each  memory strobes
- ir_wr  out  1  IR load enable
- mem_to_reg  out  1  write-back select: 1 = MDR
- reg_dst  out  1  destination select: 1 = rd, 0 = rt
- reg_wr  out  1  register file write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = A register
- alu_src_b  out  2  ALU B select: 00 = B register, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2
- alu_ctrl  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_src  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- sign_ext  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend
- instr_done  out  1  one-cycle pulse on the last cycle of a retired instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported op or funct
- mem_timeout  out  1  one-cycle pulse when the wait reaches WAIT_LIMIT

## Operation
- Outputs are decoded from the current state, plus the listed inputs where stated. Any output not listed for a state is 0, except sign_ext, which defaults to 1.
- FETCH:
  - Drives iord=0, mem_rd=1, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_src=00.
  - When mem_ready=1: ir_wr=1 and pc_en=1, then go to DECODE. Otherwise stay in FETCH.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, add, which precomputes the branch target into ALUOut.
  - Dispatch: lw/sw → MEM_ADR; R-type with a valid funct → EXEC_R; addi/slti/ori/andi → EXEC_I; beq/bne → BRANCH; j → JUMP.
  - Any other op or funct: illegal_op=1, go to FETCH.
- MEM_ADR: alu_src_a=1, alu_src_b=10, add. Then lw → MEM_RD, sw → MEM_WR.
- MEM_RD: iord=1, mem_rd=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_wr=1, instr_done=1. Go to FETCH.
- MEM_WR: iord=1, mem_wr=1. Wait for mem_ready; on it, instr_done=1 and go to FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_ctrl taken from funct. Go to R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_wr=1, instr_done=1. Go to FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_ctrl taken from op.
  - sign_ext=1 for addi/slti; sign_ext=0 for ori/andi.
  - Go to I_WB.
- I_WB: same immediate decode as EXEC_I is held, reg_dst=0, reg_wr=1, instr_done=1. Go to FETCH.
- BRANCH:
  - Drives alu_src_a=1, alu_src_b=00, sub, pc_src=01, instr_done=1.
  - pc_en = zero for beq; pc_en = !zero for bne. The is_bne bit is latched in DECODE.
  - Go to FETCH.
- JUMP: pc_src=10, pc_en=1, instr_done=1. Go to FETCH.

## Timing
- Reset: the state becomes FETCH and the wait counter clears to 0. Outputs after reset are the FETCH values, with pc_en=ir_wr=0 while mem_ready=0. All pulse outputs are 0.
- Reset mid-instruction: the next state is FETCH unconditionally. No further reg_wr or mem_wr is issued for the interrupted instruction.
- Latency with zero wait states:
  - lw: 5 cycles.
  - sw, R-type, I-type: 4 cycles.
  - beq, bne, j: 3 cycles.
  - Each cycle with mem_ready low in a wait state adds 1 cycle.
- Wait counter (8 bits):
  - Clears on entry to FETCH, MEM_RD or MEM_WR.
  - Increments on each cycle in one of those states with mem_ready=0.
  - When it equals WAIT_LIMIT and mem_ready is still 0: mem_timeout=1, go to FETCH. No instr_done, reg_wr or pc_en for that access.
  - mem_ready=1 on the limit cycle completes the access normally, with no timeout.
- mem_ready arriving in a non-wait state is ignored.

## Structure
- Shared `mips_defs` package holds:
  - Opcode and funct constants.
  - The ALU code constants (ADD, SUB, AND, OR, SLT).
  - The alu_src_b and pc_src encodings.
- The state encoding is a 4-bit localparam, private to this block.
- Sub-module `mc_wait_timer`: wait counter with clear, enable and limit-hit output.

## Test plan
- add, 0 wait: op=0, funct=0x20, mem_ready=1 → 4 cycles. R_WB has reg_dst=1, reg_wr=1, alu_ctrl was 010 in EXEC_R, instr_done pulses once.
- lw with 2 wait cycles on the data read → MEM_RD held 3 cycles. MEM_WB has reg_dst=0, mem_to_reg=1. Total 7 cycles.
- beq, zero=1 → BRANCH has pc_en=1, pc_src=01. bne, zero=1 → pc_en=0. Both take 3 cycles.
- ori → EXEC_I has sign_ext=0, alu_ctrl=001. slti → sign_ext=1, alu_ctrl=111.
- op=0x3F, and op=0 with funct=0x27 → illegal_op pulse in DECODE, next state FETCH, no reg_wr.
- WAIT_LIMIT=4 with mem_ready stuck low in MEM_WR → mem_timeout on the 4th wait cycle, then FETCH. rst asserted during MEM_RD → FETCH next cycle, with no reg_wr afterwards.
